// File: rtl/conv_pkg.sv
// Shared constants, state type and helpers for the binary32 3x3 convolution engine.
package conv_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned BIAS  = 127;

  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
  localparam logic [31:0] FP32_PINF = 32'h7F800000;

  localparam int unsigned TAPS = 9;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Leading-zero count of the 28-bit aligned sum (28 when the input is zero).
  function automatic logic [4:0] lzc28(input logic [27:0] v);
    logic [4:0] n;
    logic       hit;
    n   = 5'd0;
    hit = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      if (v[i]) hit = 1'b1;
      else if (!hit) n = n + 5'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/fp32_mul_add.sv
// Combinational y = c + a*b in binary32: product and sum each truncated toward zero,
// subnormals flushed to zero, overflow to inf, canonical NaN for invalid operations.
module fp32_mul_add
  import conv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] y
);

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;
  logic c_zero, c_inf, c_nan;
  logic p_zero, p_inf, p_nan;

  // Exponent field 0 means zero or subnormal; both are treated as signed zero.
  assign a_zero = (a[30:23] == 8'h00);
  assign a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
  assign a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
  assign b_zero = (b[30:23] == 8'h00);
  assign b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
  assign b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
  assign c_zero = (c[30:23] == 8'h00);
  assign c_inf  = (c[30:23] == 8'hFF) && (c[22:0] == 23'h0);
  assign c_nan  = (c[30:23] == 8'hFF) && (c[22:0] != 23'h0);

  logic               p_sign;
  logic [47:0]        prod;
  logic signed [10:0] p_exp;
  logic [31:0]        p;

  // Exact 48-bit mantissa product, truncated to binary32
  always_comb begin
    p_sign = a[31] ^ b[31];
    prod   = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
    p_exp  = 11'(a[30:23]) + 11'(b[30:23]) - 11'(BIAS) + 11'(prod[47]);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) p = FP32_QNAN;
    else if (a_inf || b_inf)                                      p = {p_sign, FP32_PINF[30:0]};
    else if (a_zero || b_zero)                                    p = {p_sign, 31'h0};
    else if (p_exp >= 11'sd255)                                   p = {p_sign, FP32_PINF[30:0]};
    else if (p_exp <= 11'sd0)                                     p = {p_sign, 31'h0};
    else if (prod[47])                            p = {p_sign, p_exp[7:0], prod[46:24]};
    else                                          p = {p_sign, p_exp[7:0], prod[45:23]};
  end

  assign p_zero = (p[30:23] == 8'h00);
  assign p_inf  = (p[30:23] == 8'hFF) && (p[22:0] == 23'h0);
  assign p_nan  = (p[30:23] == 8'hFF) && (p[22:0] != 23'h0);

  logic [31:0]        big, sml;
  logic               eff_sub, sticky;
  logic [7:0]         e_diff;
  logic [4:0]         sh, lz;
  logic [58:0]        sml_wide;
  logic [26:0]        x_al, y_al;
  logic [27:0]        sum, norm;
  logic signed [10:0] r_exp;
  logic [31:0]        sum_res;

  // Aligned add of two normal operands, truncated toward zero
  always_comb begin
    if (p[30:0] >= c[30:0]) begin
      big = p;
      sml = c;
    end else begin
      big = c;
      sml = p;
    end
    eff_sub  = big[31] ^ sml[31];
    e_diff   = big[30:23] - sml[30:23];
    sh       = (e_diff > 8'd31) ? 5'd31 : e_diff[4:0];
    sml_wide = {1'b1, sml[22:0], 35'h0} >> sh;
    y_al     = sml_wide[58:32];
    sticky   = |sml_wide[31:0];
    x_al     = {1'b1, big[22:0], 3'b000};
    // Borrowing one unit when bits were shifted out keeps the truncated magnitude exact
    if (eff_sub) sum = {1'b0, x_al} - {1'b0, y_al} - {27'h0, sticky};
    else         sum = {1'b0, x_al} + {1'b0, y_al};
    lz    = lzc28(sum);
    norm  = sum << lz;
    r_exp = 11'(big[30:23]) + 11'sd1 - 11'(lz);
    if (sum == 28'h0)            sum_res = 32'h0;
    else if (r_exp >= 11'sd255)  sum_res = {big[31], FP32_PINF[30:0]};
    else if (r_exp <= 11'sd0)    sum_res = {big[31], 31'h0};
    else                         sum_res = {big[31], r_exp[7:0], norm[26:4]};
  end

  // Special-value resolution ahead of the normal-path sum
  always_comb begin
    if (p_nan || c_nan || (p_inf && c_inf && (p[31] != c[31]))) y = FP32_QNAN;
    else if (p_inf)                                             y = p;
    else if (c_inf)                                             y = c;
    else if (p_zero && c_zero)                                  y = {p[31] & c[31], 31'h0};
    else if (p_zero)                                            y = c;
    else if (c_zero)                                            y = p;
    else                                                        y = sum_res;
  end

endmodule

// File: rtl/conv2d_fp32.sv
// 3x3 binary32 convolution tap engine: one multiply-add per cycle over latched operands.
module conv2d_fp32
  import conv_pkg::*;
#(
  parameter int unsigned KSIZE  = 3,
  parameter int unsigned DATA_W = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_i,
  input  logic [KSIZE*KSIZE*DATA_W-1:0] window_i,
  input  logic [KSIZE*KSIZE*DATA_W-1:0] weight_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [DATA_W-1:0]             result_o
);

  localparam int unsigned NTAP  = KSIZE * KSIZE;
  localparam int unsigned VEC_W = NTAP * DATA_W;
  localparam logic [3:0]  LAST  = 4'(NTAP - 1);

  state_e             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic [VEC_W-1:0]   win_q, win_d, wt_q, wt_d;
  logic [DATA_W-1:0]  acc_q, acc_d, result_q, result_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  px, wk, mac;

  assign px = win_q[DATA_W*k_q +: DATA_W];
  assign wk = wt_q[DATA_W*k_q +: DATA_W];

  fp32_mul_add u_mac (
    .a (px),
    .b (wk),
    .c (acc_q),
    .y (mac)
  );

  // Next-state: latch on start, accumulate one tap per RUN cycle, publish in DONE
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    win_d    = win_q;
    wt_d     = wt_q;
    acc_d    = acc_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          win_d   = window_i;
          wt_d    = weight_i;
          acc_d   = '0;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = mac;
        k_d   = k_q + 4'd1;
        if (k_q == LAST) state_d = DONE;
      end
      DONE: begin
        result_d = acc_q;
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      win_q    <= '0;
      wt_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      win_q    <= win_d;
      wt_q     <= wt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_conv2d_fp32.sv
// Self-checking bench for conv2d_fp32 against a real-arithmetic reference model.
module tb_conv2d_fp32;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] ONE  = 32'h3F800000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [287:0] window = '0;
  logic [287:0] weight = '0;
  logic         busy, done;
  logic [31:0]  result;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv2d_fp32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start),
    .window_i (window),
    .weight_i (weight),
    .busy_o   (busy),
    .done_o   (done),
    .result_o (result)
  );

  // ---------------- reference model ----------------
  function automatic logic [31:0] ftz(input logic [31:0] x);
    if (x[30:23] == 8'h00) return {x[31], 31'h0};
    return x;
  endfunction

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == 0);
  endfunction

  function automatic bit is_zero(input logic [31:0] x);
    return x[30:0] == 0;
  endfunction

  // Exact widening of a normal binary32 to double.
  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  // Exact double value -> binary32 truncated toward zero, flush-to-zero, overflow to inf.
  function automatic logic [31:0] rtz(input real r);
    logic [63:0] d;
    int          fe;
    d = $realtobits(r);
    if (d[62:0] == 0) return {d[63], 31'h0};
    fe = int'(d[62:52]) - 1023 + 127;
    if (fe >= 255) return {d[63], 8'hFF, 23'h0};
    if (fe <= 0) return {d[63], 31'h0};
    return {d[63], fe[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a0, input logic [31:0] b0);
    logic [31:0] a, b;
    logic        s;
    a = ftz(a0);
    b = ftz(b0);
    s = a[31] ^ b[31];
    if (is_nan(a) || is_nan(b)) return QNAN;
    if ((is_inf(a) && is_zero(b)) || (is_inf(b) && is_zero(a))) return QNAN;
    if (is_inf(a) || is_inf(b)) return {s, 8'hFF, 23'h0};
    if (is_zero(a) || is_zero(b)) return {s, 31'h0};
    return rtz(to_real(a) * to_real(b));
  endfunction

  function automatic logic [31:0] ref_add(input logic [31:0] c0, input logic [31:0] p0);
    logic [31:0] c, p, big, v;
    int          ed;
    c = ftz(c0);
    p = ftz(p0);
    if (is_nan(c) || is_nan(p)) return QNAN;
    if (is_inf(c) && is_inf(p)) return (c[31] == p[31]) ? c : QNAN;
    if (is_inf(c)) return c;
    if (is_inf(p)) return p;
    if (is_zero(c) && is_zero(p)) return {c[31] & p[31], 31'h0};
    if (is_zero(c)) return p;
    if (is_zero(p)) return c;
    ed = int'(c[30:23]) - int'(p[30:23]);
    if (ed > 28 || ed < -28) begin
      // Smaller addend lies far below one ulp of the larger one.
      big = (ed > 0) ? c : p;
      if (c[31] == p[31]) return big;
      v = {1'b0, big[30:0]} - 32'd1;
      if (v[30:23] == 8'h00) return {big[31], 31'h0};
      return {big[31], v[30:0]};
    end
    return rtz(to_real(c) + to_real(p));
  endfunction

  function automatic logic [31:0] ref_conv(input logic [287:0] win, input logic [287:0] wt);
    logic [31:0] acc;
    acc = 32'h0;
    for (int k = 0; k < 9; k++) acc = ref_add(acc, ref_mul(win[32*k +: 32], wt[32*k +: 32]));
    return acc;
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [287:0] one_tap(input int k, input logic [31:0] v);
    logic [287:0] r;
    r = '0;
    r[32*k +: 32] = v;
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    if ($urandom_range(0, 15) == 0) return 32'h0;
    e = 8'($urandom_range(110, 144));
    return {1'($urandom_range(0, 1)), e, 23'($urandom())};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Start a convolution, scramble inputs after acceptance, and check timing and result.
  task automatic run_conv(input string tag, input logic [287:0] win, input logic [287:0] wt,
                          input logic [31:0] exp_v);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    window = win;
    weight = wt;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      window[32*k +: 32] = $urandom();
      weight[32*k +: 32] = $urandom();
    end
    cyc     = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 20) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd10);
    check({tag, " busy"}, 32'(busy_ok), 32'd1);
    check({tag, " result"}, result, exp_v);
    @(negedge clk);
    check({tag, " pulse"}, 32'(done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  localparam logic [287:0] ONES = {9{32'h3F800000}};

  initial begin
    logic [287:0] win, wt;
    logic [31:0]  e2, v;
    int           ndone;

    // Reset state
    #12;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // All ones -> 9.0
    run_conv("ones", ONES, ONES, 32'h41100000);

    // Single negative*negative tap, then operands swapped
    win = one_tap(0, 32'hBFB10868);
    wt  = one_tap(0, 32'hBF9FD2A6);
    e2  = ref_conv(win, wt);
    run_conv("negneg", win, wt, e2);
    run_conv("negneg swap", wt, win, e2);

    // Exact cancellation -> +0, then product overflow -> +inf
    win = one_tap(0, 32'h3FC00000) | one_tap(1, 32'hBFC00000);
    wt  = one_tap(0, 32'h40000000) | one_tap(1, 32'h40000000);
    run_conv("cancel", win, wt, 32'h00000000);
    run_conv("overflow", one_tap(0, 32'h7F000000), one_tap(0, 32'h40000000), 32'h7F800000);

    // Far-below opposite-sign addend truncates to the predecessor of 1.0
    win = one_tap(0, ONE) | one_tap(1, 32'hB0800000);
    wt  = one_tap(0, ONE) | one_tap(1, ONE);
    run_conv("sticky", win, wt, 32'h3F7FFFFF);

    // Specials: inf*0, NaN operand, subnormal flushed
    run_conv("inf0", one_tap(0, 32'h7F800000), one_tap(0, 32'h0), QNAN);
    win = ONES;
    win[32*3 +: 32] = 32'h7FC12345;
    run_conv("nan", win, ONES, QNAN);
    run_conv("subnormal", one_tap(0, 32'h00000001), one_tap(0, ONE), 32'h00000000);

    // Random windows, some with near-cancelling neighbour taps
    for (int t = 0; t < 14; t++) begin
      for (int k = 0; k < 9; k++) begin
        win[32*k +: 32] = rnd_fp();
        wt[32*k +: 32]  = rnd_fp();
        if (k > 0 && $urandom_range(0, 2) == 0) begin
          v = win[32*(k-1) +: 32] ^ 32'h80000000;
          v[3:0] = 4'($urandom());
          win[32*k +: 32] = v;
          wt[32*k +: 32]  = wt[32*(k-1) +: 32];
        end
      end
      run_conv($sformatf("rand%0d", t), win, wt, ref_conv(win, wt));
    end

    // Starts during RUN (k=3) and in the DONE cycle are ignored
    @(negedge clk);
    window = ONES;
    weight = ONES;
    start  = 1'b1;
    @(negedge clk);
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      start = (i == 3 || i == 9);
      @(negedge clk);
      if (done) ndone++;
    end
    start = 1'b0;
    check("ignored starts done count", 32'(ndone), 32'd1);
    check("ignored starts idle", 32'(busy), 32'd0);
    check("ignored starts result", result, 32'h41100000);
    run_conv("after ignored", one_tap(2, 32'h40400000), one_tap(2, 32'h40000000), 32'h40C00000);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    window = ONES;
    weight = ONES;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset done", 32'(done), 32'd0);
    check("async reset result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("aborted run no done", 32'(ndone), 32'd0);
    run_conv("post reset ones", ONES, ONES, 32'h41100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/conv2d_fp32.md
Name: conv2d_fp32

Overview:
3x3 single-precision (IEEE-754 binary32) convolution tap engine for the CNN datapath.
- Accepts one 3x3 image window and one 3x3 filter.
- Computes the sum of the 9 element-wise products with one multiply-add per cycle.
- Presents the scalar result with a done pulse.
- The image-scanning controller feeds it windows and collects results into the output feature map.

Parameters:
KSIZE, 3, kernel edge length. Tap count is KSIZE*KSIZE. Only 3 is required to work.
DATA_W, 32, element width. Fixed at binary32.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start_i  in  1  request a new convolution. Sampled only in IDLE.
window_i  in  288  pixel k at bits [32k+31:32k], where k = row*3+col
weight_i  in  288  filter tap k, same packing as window_i
busy_o  out  1  high from the cycle after start is accepted until done_o
done_o  out  1  one-cycle pulse when result_o is updated
result_o  out  32  binary32 sum of products. Held until the next done_o.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, busy_o=0, done_o=0, result_o=0x00000000.
  - Accumulator and tap counter cleared.
  - Reset during RUN aborts the operation; no done_o is produced.
- States:
  - IDLE: on start_i=1, latch window_i and weight_i, acc=+0, k=0, go to RUN.
  - RUN: each cycle, acc <= acc + px[k]*w[k], k++. After k=8, go to DONE (9 cycles in RUN).
  - DONE: result_o <= acc, done_o=1 for this single cycle, then IDLE.
- Latency: start sampled at edge N gives done_o=1 in the cycle after edge N+10.
- busy_o=1 in RUN and DONE.
- start_i is ignored in RUN and DONE, including a start in the DONE cycle. Inputs may change freely after acceptance.
- Arithmetic, per tap:
  - Multiply, rounded to binary32 toward zero (RTZ).
  - Add to acc, rounded RTZ. Two roundings per tap, not fused.
- Special values:
  - Subnormal operands and results flush to zero (sign kept).
  - Overflow gives ±inf.
  - Any NaN operand, inf*0, or inf+(-inf) gives canonical NaN 0x7FC00000, which is sticky in acc.
  - Inf otherwise propagates with its sign.
  - An exact-zero sum is +0, unless both addends are -0.
- The product of a non-special pair is exact before rounding: 48-bit mantissa product. The add aligns using guard/round/sticky bits; truncation must still be bit-exact RTZ.

Decomposition:
- Package conv_pkg holds:
  - FP32 field constants: EXP_W=8, MAN_W=23, BIAS=127.
  - FP32_QNAN=0x7FC00000, FP32_PINF=0x7F800000.
  - TAPS=9.
  - State enum {IDLE, RUN, DONE}.
- Sub-module fp32_mul_add:
  - Combinational: inputs a, b, c; output c + a*b.
  - Implements both RTZ roundings and all special-value rules.
  - The top module is the FSM, latches and tap mux.

Test Plan:
1. All pixels 0x3F800000 (1.0) and all weights 1.0, start → result_o=0x41100000 (9.0), done_o exactly 10 cycles after start, busy_o high for those cycles.
2. px0=0xBFB10868 (-1.383069), w0=0xBF9FD2A6 (-1.248616), all other taps 0 → result ≈ +1.72692, bit-exact to the RTZ reference model. Then swap px0/w0 → same bits.
3. Tap 0 = x*a and tap 1 = (-x)*a (x=1.5, a=2.0), rest 0 → result_o=0x00000000 (+0). Repeat with px0=0x7F000000, w0=0x40000000 → 0x7F800000.
4. px0=0x7F800000 (inf), w0=0 → 0x7FC00000. px3=NaN with everything else finite → 0x7FC00000. Subnormal px (0x00000001) × 1.0 → contributes 0.
5. start_i pulsed at RUN k=3 and in the DONE cycle → ignored, exactly one done_o. Next start in IDLE is accepted.
6. rst_n low at RUN k=4 → busy_o, done_o, result_o=0 immediately (asynchronous). After release, a fresh start completes case 1 correctly.
